// File: rtl/char_plane_pkg.sv
// Shared types and constants for the character-plane write sequencer.
package char_plane_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCROLL = 2'd1,
        ST_CLEAR  = 2'd2
    } state_e;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BLANK = 8'h20;

    localparam int ROWS  = 16;
    localparam int COLS  = 64;
    localparam int ROW_W = 4;
    localparam int COL_W = 6;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the grant history advances only on an accepted transfer.
module rr_arbiter2 (
    input  logic clock,
    input  logic reset_n,
    input  logic inhibit_i,
    input  logic valid0_i,
    input  logic valid1_i,
    output logic ready0_o,
    output logic ready1_o,
    output logic xfer_o
);

    logic last_grant_q, last_grant_d;

    always_comb begin
        ready0_o = 1'b0;
        ready1_o = 1'b0;
        if (!inhibit_i) begin
            if (valid0_i && valid1_i) begin
                ready0_o = last_grant_q;
                ready1_o = !last_grant_q;
            end else begin
                ready0_o = valid0_i;
                ready1_o = valid1_i;
            end
        end
    end

    // Ready is only raised alongside valid, so ready alone marks a transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (ready0_o)
            last_grant_d = 1'b0;
        else if (ready1_o)
            last_grant_d = 1'b1;
    end

    assign xfer_o = ready0_o | ready1_o;

    always_ff @(posedge clock) begin
        if (!reset_n)
            last_grant_q <= 1'b1;
        else
            last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/char_plane_sequencer.sv
// Owns the character-plane write port: arbitrates two byte streams, tracks the cursor,
// handles control codes, pulses scroll and sweeps the plane blank on clear.
//
// state  | meaning
// IDLE   | accepting characters from the requesters
// SCROLL | one-cycle push_up pulse, requesters held off
// CLEAR  | row-major blanking sweep of the whole plane
module char_plane_sequencer
    import char_plane_pkg::*;
#(
    parameter int         ROWS  = char_plane_pkg::ROWS,
    parameter int         COLS  = char_plane_pkg::COLS,
    parameter int         ROW_W = char_plane_pkg::ROW_W,
    parameter int         COL_W = char_plane_pkg::COL_W,
    parameter logic [7:0] BLANK = char_plane_pkg::CH_BLANK
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req0_valid,
    input  logic [7:0]       req0_char,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_char,
    output logic             req1_ready,
    input  logic             clear_req,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_char,
    output logic             push_up,
    output logic             busy,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col
);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    state_e                   state_q, state_d;
    logic [ROW_W-1:0]         row_q, row_d;
    logic [COL_W-1:0]         col_q, col_d;
    logic [ROW_W+COL_W-1:0]   sweep_q, sweep_d;
    logic                     wr_en_q, wr_en_d;
    logic [ROW_W-1:0]         wr_row_q, wr_row_d;
    logic [COL_W-1:0]         wr_col_q, wr_col_d;
    logic [7:0]               wr_char_q, wr_char_d;

    logic                     inhibit, xfer;
    logic [7:0]               ch;
    logic [ROW_W-1:0]         sw_row;
    logic [COL_W-1:0]         sw_col;

    assign inhibit = (state_q != ST_IDLE) || clear_req;
    assign ch      = req1_ready ? req1_char : req0_char;
    assign sw_row  = sweep_q[ROW_W+COL_W-1:COL_W];
    assign sw_col  = sweep_q[COL_W-1:0];

    rr_arbiter2 u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .inhibit_i (inhibit),
        .valid0_i  (req0_valid),
        .valid1_i  (req1_valid),
        .ready0_o  (req0_ready),
        .ready1_o  (req1_ready),
        .xfer_o    (xfer)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            col_q     <= '0;
            sweep_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_row_q  <= '0;
            wr_col_q  <= '0;
            wr_char_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            sweep_q   <= sweep_d;
            wr_en_q   <= wr_en_d;
            wr_row_q  <= wr_row_d;
            wr_col_q  <= wr_col_d;
            wr_char_q <= wr_char_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        sweep_d   = sweep_q;
        wr_en_d   = 1'b0;
        wr_row_d  = wr_row_q;
        wr_col_d  = wr_col_q;
        wr_char_d = wr_char_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    sweep_d = '0;
                end else if (xfer) begin
                    case (ch)
                        CH_LF: begin
                            col_d = '0;
                            if (row_q == ROW_LAST)
                                state_d = ST_SCROLL;
                            else
                                row_d = row_q + ROW_W'(1);
                        end
                        CH_BS: begin
                            if (col_q != '0) begin
                                col_d     = col_q - COL_W'(1);
                                wr_en_d   = 1'b1;
                                wr_row_d  = row_q;
                                wr_col_d  = col_q - COL_W'(1);
                                wr_char_d = BLANK;
                            end
                        end
                        CH_FF: begin
                            state_d = ST_CLEAR;
                            sweep_d = '0;
                        end
                        default: begin
                            wr_en_d   = 1'b1;
                            wr_row_d  = row_q;
                            wr_col_d  = col_q;
                            wr_char_d = ch;
                            if (col_q != COL_LAST) begin
                                col_d = col_q + COL_W'(1);
                            end else begin
                                col_d = '0;
                                if (row_q == ROW_LAST)
                                    state_d = ST_SCROLL;
                                else
                                    row_d = row_q + ROW_W'(1);
                            end
                        end
                    endcase
                end
            end
            ST_SCROLL: state_d = ST_IDLE;
            ST_CLEAR: begin
                wr_en_d   = 1'b1;
                wr_row_d  = sw_row;
                wr_col_d  = sw_col;
                wr_char_d = BLANK;
                // Explicit terminal compares keep non-power-of-2 geometries correct.
                if (sw_col == COL_LAST) begin
                    if (sw_row == ROW_LAST) begin
                        state_d = ST_IDLE;
                        row_d   = '0;
                        col_d   = '0;
                    end else begin
                        sweep_d = {sw_row + ROW_W'(1), {COL_W{1'b0}}};
                    end
                end else begin
                    sweep_d = {sw_row, sw_col + COL_W'(1)};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        push_up = (state_q == ST_SCROLL);
        busy    = (state_q != ST_IDLE);
        wr_en   = wr_en_q;
        wr_row  = wr_row_q;
        wr_col  = wr_col_q;
        wr_char = wr_char_q;
        cur_row = row_q;
        cur_col = col_q;
    end

endmodule
